frame_sequencer: RTL and testbench

//  Per-frame controller for the GPU back end. Sequences: z-buffer clear, rasterizer run

---
 rtl/frame_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Per-frame controller for the GPU back end. One frame runs through:
//   1. z-buffer clear
//   2. the rasterizer, one triangle at a time, for each triangle of the frame
//   3. a wireframe SRAM bank flip
//   4. a parallel colorloop pass across NUM_CF_MODS modules
//   5. a frame-buffer flip aligned to display vsync
//
// This block is the only driver of ras_start, cl_start, wf_flip and fb_flip.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   frame_start     frame request, honoured only in IDLE
//   tri_count       triangles in the frame, latched with an accepted frame_start
//   zb_clear_start  1-cycle pulse to the z-buffer clear engine
//   zb_clear_done   completion pulse from the z-buffer clear engine
//   ras_start       1-cycle pulse: rasterize triangle tri_idx
//   tri_idx         current triangle index
//   ras_done        rasterizer finished the current triangle
//   wf_flip         1-cycle pulse: swap wireframe SRAM banks
//   cl_start        1-cycle pulse to every colorloop module, all bits together
//   cl_done         per-module completion pulses, any order or overlap
//   vsync           display vertical-sync pulse
//   fb_flip         1-cycle pulse: swap frame-buffer banks
//   busy            high in every state except IDLE
//   frame_done      1-cycle pulse at the end of a frame
//   frame_drop      1-cycle pulse: a frame_start arrived while busy
//
// Every output is a register. Each pulse is set on the same clock edge as the
// state transition that issues it, so the pulse is high for the whole first
// cycle of the new state.
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int NUM_CF_MODS = 4,
  parameter int TRI_CNT_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [TRI_CNT_W-1:0]   tri_count,
  output logic                   zb_clear_start,
  input  logic                   zb_clear_done,
  output logic                   ras_start,
  output logic [TRI_CNT_W-1:0]   tri_idx,
  input  logic                   ras_done,
  output logic                   wf_flip,
  output logic [NUM_CF_MODS-1:0] cl_start,
  input  logic [NUM_CF_MODS-1:0] cl_done,
  input  logic                   vsync,
  output logic                   fb_flip,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_drop
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ZCLR       = 3'd1,
    S_RAS_ISSUE  = 3'd2,
    S_RAS_WAIT   = 3'd3,
    S_WF_FLIP    = 3'd4,
    S_CL_WAIT    = 3'd5,
    S_VSYNC_WAIT = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  localparam logic [NUM_CF_MODS-1:0] ALL_DONE = {NUM_CF_MODS{1'b1}};
  localparam logic [TRI_CNT_W-1:0]   TRI_ONE  = {{(TRI_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [TRI_CNT_W-1:0]   cnt_r;
  logic [NUM_CF_MODS-1:0] done_mask_r;
  logic [NUM_CF_MODS-1:0] done_mask_next_s;

  // Sticky completion set including this cycle's pulses. This lets a module
  // finishing in the same cycle as the last outstanding one close the pass
  // immediately.
  always_comb begin
    done_mask_next_s = done_mask_r | cl_done;
  end

  // Frame sequencing state machine. All outputs are updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      cnt_r          <= {TRI_CNT_W{1'b0}};
      done_mask_r    <= {NUM_CF_MODS{1'b0}};
      tri_idx        <= {TRI_CNT_W{1'b0}};
      zb_clear_start <= 1'b0;
      ras_start      <= 1'b0;
      wf_flip        <= 1'b0;
      cl_start       <= {NUM_CF_MODS{1'b0}};
      fb_flip        <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frame_drop     <= 1'b0;
    end else begin
      // Pulses default low; only the issuing transition raises them.
      zb_clear_start <= 1'b0;
      ras_start      <= 1'b0;
      wf_flip        <= 1'b0;
      cl_start       <= {NUM_CF_MODS{1'b0}};
      fb_flip        <= 1'b0;
      frame_done     <= 1'b0;
      // A request in any non-IDLE state, DONE included, is dropped and reported.
      frame_drop     <= frame_start && (state_r != S_IDLE);

      case (state_r)
        S_IDLE: begin
          if (frame_start) begin
            cnt_r          <= tri_count;
            tri_idx        <= {TRI_CNT_W{1'b0}};
            zb_clear_start <= 1'b1;
            busy           <= 1'b1;
            state_r        <= S_ZCLR;
          end else begin
            state_r        <= S_IDLE;
          end
        end

        S_ZCLR: begin
          if (zb_clear_done) begin
            if (cnt_r == {TRI_CNT_W{1'b0}}) begin
              // An empty frame skips the rasterizer entirely.
              wf_flip   <= 1'b1;
              state_r   <= S_WF_FLIP;
            end else begin
              ras_start <= 1'b1;
              state_r   <= S_RAS_ISSUE;
            end
          end else begin
            state_r <= S_ZCLR;
          end
        end

        // ras_start is high in this cycle. ras_done is deliberately not looked
        // at here, so the pulses are always at least two cycles apart.
        S_RAS_ISSUE: begin
          state_r <= S_RAS_WAIT;
        end

        S_RAS_WAIT: begin
          if (ras_done) begin
            // cnt_r is non-zero here, so cnt_r - 1 cannot wrap.
            if (tri_idx == (cnt_r - TRI_ONE)) begin
              wf_flip   <= 1'b1;
              state_r   <= S_WF_FLIP;
            end else begin
              tri_idx   <= tri_idx + TRI_ONE;
              ras_start <= 1'b1;
              state_r   <= S_RAS_ISSUE;
            end
          end else begin
            state_r <= S_RAS_WAIT;
          end
        end

        S_WF_FLIP: begin
          done_mask_r <= {NUM_CF_MODS{1'b0}};
          cl_start    <= ALL_DONE;
          state_r     <= S_CL_WAIT;
        end

        S_CL_WAIT: begin
          done_mask_r <= done_mask_next_s;
          if (done_mask_next_s == ALL_DONE) begin
            state_r <= S_VSYNC_WAIT;
          end else begin
            state_r <= S_CL_WAIT;
          end
        end

        // vsync is only meaningful here; earlier pulses never reach this branch.
        S_VSYNC_WAIT: begin
          if (vsync) begin
            fb_flip <= 1'b1;
            state_r <= S_DONE;
          end else begin
            state_r <= S_VSYNC_WAIT;
          end
        end

        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Self-checking bench for frame_sequencer.
//
// Each frame is described as a timeline of per-cycle records. A record holds
// the inputs driven in that cycle and the outputs expected in that cycle.
//
// The expected timeline is derived from the frame-level latency rules:
//   - Each pulse follows its trigger by one cycle.
//   - A triangle occupies its ras_start cycle plus its wait cycles.
//   - The colorloop pass completes in the cycle the union of the done bits
//     becomes all ones.
//   - The first vsync after that completion produces fb_flip, and frame_done
//     follows one cycle later.
//
// Misplaced inputs are sprinkled into states that must ignore them.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

  localparam int NCF  = 4;
  localparam int TW   = 10;
  localparam int MAXV = 8192;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic [TW-1:0]  tri_count;
  logic           zb_clear_start;
  logic           zb_clear_done;
  logic           ras_start;
  logic [TW-1:0]  tri_idx;
  logic           ras_done;
  logic           wf_flip;
  logic [NCF-1:0] cl_start;
  logic [NCF-1:0] cl_done;
  logic           vsync;
  logic           fb_flip;
  logic           busy;
  logic           frame_done;
  logic           frame_drop;

  frame_sequencer #(.NUM_CF_MODS(NCF), .TRI_CNT_W(TW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .tri_count(tri_count),
    .zb_clear_start(zb_clear_start), .zb_clear_done(zb_clear_done),
    .ras_start(ras_start), .tri_idx(tri_idx), .ras_done(ras_done),
    .wf_flip(wf_flip), .cl_start(cl_start), .cl_done(cl_done),
    .vsync(vsync), .fb_flip(fb_flip), .busy(busy),
    .frame_done(frame_done), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  // One cycle: inputs (fs..vs) driven in the cycle, outputs (zs..dr) expected in it.
  typedef struct packed {
    logic           fs;
    logic [TW-1:0]  tc;
    logic           zd;
    logic           rd;
    logic [NCF-1:0] cd;
    logic           vs;
    logic           zs;
    logic           rs;
    logic [TW-1:0]  ti;
    logic           wf;
    logic [NCF-1:0] cs;
    logic           fb;
    logic           bz;
    logic           fd;
    logic           dr;
  } vec_t;

  vec_t          vt [MAXV];
  int            nv;
  logic [TW-1:0] last_ti;
  int            n_cmp;
  int            n_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input vec_t e, input string nm, input int cyc);
    logic [20:0] got;
    logic [20:0] exp;
    got = {zb_clear_start, ras_start, tri_idx, wf_flip, cl_start, fb_flip, busy, frame_done, frame_drop};
    exp = {e.zs, e.rs, e.ti, e.wf, e.cs, e.fb, e.bz, e.fd, e.dr};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got zs=%b rs=%b ti=%0d wf=%b cs=%b fb=%b busy=%b fd=%b drop=%b, want zs=%b rs=%b ti=%0d wf=%b cs=%b fb=%b busy=%b fd=%b drop=%b",
               nm, cyc, zb_clear_start, ras_start, tri_idx, wf_flip, cl_start, fb_flip, busy, frame_done, frame_drop,
               e.zs, e.rs, e.ti, e.wf, e.cs, e.fb, e.bz, e.fd, e.dr);
    end
  endtask

  task automatic drive(input vec_t v);
    frame_start   = v.fs;
    tri_count     = v.tc;
    zb_clear_done = v.zd;
    ras_done      = v.rd;
    cl_done       = v.cd;
    vsync         = v.vs;
  endtask

  // Grow the timeline with idle records up to and including index upto.
  task automatic ext(input int upto);
    if (upto >= MAXV) begin
      $display("FAIL table_overflow: need %0d records, have %0d", upto + 1, MAXV);
      $fatal(1, "timeline table exhausted");
    end
    while (nv <= upto) begin
      vt[nv]    = '0;
      vt[nv].ti = last_ti;
      vt[nv].tc = TW'($urandom);
      nv++;
    end
  endtask

  // Append one frame. gap: cycles after the last record before frame_start.
  // dz/drf: clear and per-triangle latency (0 = random). clpat: fixed cl_done
  // pattern. vsn: vsync in RAS_WAIT and CL_WAIT. hold: frame_start held high.
  // noisy: random misplaced inputs.
  task automatic build_frame(input int n, input int gap, input int dz, input int drf,
                             input bit clpat, input bit vsn, input bit hold, input bit noisy);
    int t0, c, t, d, k, v, x;
    int tb [NCF];
    t0 = nv - 1 + gap;
    ext(t0);
    vt[t0].fs = 1'b1;
    vt[t0].tc = TW'(n);
    if (noisy && gap > 0) begin
      vt[t0-1].zd = 1'b1;
      vt[t0-1].rd = 1'b1;
      vt[t0-1].cd = '1;
      vt[t0-1].vs = 1'b1;
    end
    last_ti = '0;
    c = t0 + 1 + ((dz > 0) ? dz : int'($urandom_range(4, 1)));
    ext(c + 1);
    vt[t0+1].zs = 1'b1;
    vt[c].zd    = 1'b1;
    t = c + 1;
    for (int i = 0; i < n; i++) begin
      d = (drf > 0) ? drf : int'($urandom_range(4, 1));
      ext(t + d + 1);
      vt[t].rs   = 1'b1;
      vt[t+d].rd = 1'b1;
      for (int j = t; j <= t + d; j++) vt[j].ti = TW'(i);
      if (vsn && i == 0) vt[t+1].vs = 1'b1;
      if (noisy && $urandom_range(1, 0) == 1) vt[t].rd = 1'b1;
      t = t + d + 1;
    end
    last_ti = (n == 0) ? '0 : TW'(n - 1);
    ext(t + 1);
    vt[t].wf   = 1'b1;
    vt[t+1].cs = '1;
    k = t + 1;
    if (clpat) begin
      ext(t + 4);
      vt[t+1].cd = 4'b0001;
      vt[t+2].cd = 4'b0001;
      vt[t+3].cd = 4'b1000;
      vt[t+4].cd = 4'b0110;
      k = t + 4;
    end else begin
      for (int b = 0; b < NCF; b++) begin
        tb[b] = t + 1 + int'($urandom_range(4, 0));
        ext(tb[b]);
        vt[tb[b]].cd[b] = 1'b1;
        if (tb[b] > k) k = tb[b];
      end
      if (noisy) begin
        for (int b = 0; b < NCF; b++) begin
          x = int'($urandom_range(k, tb[b]));
          vt[x].cd[b] = 1'b1;
        end
      end
    end
    if (vsn) vt[t+1].vs = 1'b1;
    v = k + 1 + int'($urandom_range(3, 0));
    ext(v + 2);
    vt[v].vs   = 1'b1;
    vt[v+1].fb = 1'b1;
    vt[v+2].fd = 1'b1;
    if (noisy) begin
      x = int'($urandom_range(k, t0 + 1));
      vt[x].vs = 1'b1;
      x = int'($urandom_range(v + 1, c + 1));
      vt[x].zd = 1'b1;
      x = int'($urandom_range(v + 1, t));
      vt[x].rd = 1'b1;
      x = int'($urandom_range(t, t0));
      vt[x].cd = vt[x].cd | NCF'($urandom);
    end
    for (int j = t; j <= v + 2; j++) vt[j].ti = last_ti;
    for (int j = t0 + 1; j <= v + 1; j++) begin
      vt[j].bz = 1'b1;
      if (hold || (noisy && $urandom_range(7, 0) == 0)) begin
        vt[j].fs   = 1'b1;
        vt[j].tc   = TW'($urandom);
        vt[j+1].dr = 1'b1;
      end
    end
  endtask

  task automatic apply_table(input string nm);
    for (int i = 0; i < nv; i++) begin
      check(vt[i], nm, i);
      drive(vt[i]);
      step();
    end
    drive('0);
  endtask

  initial begin
    vec_t e;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive('0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Record 0 doubles as the post-reset check.
    nv      = 0;
    last_ti = '0;
    ext(0);
    build_frame(3, 0, 5, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    build_frame(0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    build_frame(2, 1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    build_frame(2, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    build_frame(1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 20; f++) begin
      build_frame(int'($urandom_range(6, 0)), int'($urandom_range(3, 0)), 0, 0,
                  1'b0, 1'b1 & $urandom_range(1, 0), 1'b0, 1'b1);
    end
    build_frame(1023, 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_table("tbl");

    // Reset in RAS_WAIT with tri_idx=1.
    e = '0; e.ti = last_ti;
    check(e, "idle_after_table", 0);
    frame_start = 1'b1;
    tri_count   = 10'd3;
    step();
    frame_start = 1'b0;
    e = '0; e.zs = 1'b1; e.bz = 1'b1;
    check(e, "rst_seq_zclr", 1);
    zb_clear_done = 1'b1;
    step();
    zb_clear_done = 1'b0;
    e = '0; e.rs = 1'b1; e.bz = 1'b1;
    check(e, "rst_seq_issue0", 2);
    step();
    e = '0; e.bz = 1'b1;
    check(e, "rst_seq_wait0", 3);
    ras_done = 1'b1;
    step();
    ras_done = 1'b0;
    e = '0; e.rs = 1'b1; e.bz = 1'b1; e.ti = 10'd1;
    check(e, "rst_seq_issue1", 4);
    step();
    e = '0; e.bz = 1'b1; e.ti = 10'd1;
    check(e, "rst_seq_wait1", 5);
    rst     = 1'b1;
    vsync   = 1'b1;
    cl_done = '1;
    #1;
    e = '0;
    check(e, "rst_async", 6);
    step();
    check(e, "rst_hold", 7);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      zb_clear_done = 1'($urandom);
      ras_done      = 1'($urandom);
      cl_done       = NCF'($urandom);
      vsync         = 1'($urandom);
      step();
      check(e, "post_rst_quiet", 8 + i);
    end
    drive('0);

    // Recovery: a fresh frame after the abort.
    nv      = 0;
    last_ti = '0;
    ext(0);
    build_frame(2, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_table("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
